// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - fetch sequencer handshake and bus-strobe bundle
// slave is the sequencer side; master is the datapath/memory/execute side.
interface fetch_controller_if #(
  parameter int COUNT_W = 16
);
  logic               run;
  logic [31:0]        ir_value;
  logic               mem_ready;
  logic               exec_done;
  logic               PCout;
  logic               MARin;
  logic               IncPC;
  logic               Zin;
  logic               Zlowout;
  logic               PCin;
  logic               Read;
  logic               MDRin;
  logic               MDRout;
  logic               IRin;
  logic               exec_start;
  logic [4:0]         opcode;
  logic [COUNT_W-1:0] instr_count;
  logic               halted;
  logic               mem_fault;
  logic [2:0]         state;

  modport slave (
    input  run, ir_value, mem_ready, exec_done,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
    output exec_start, opcode, instr_count, halted, mem_fault, state
  );

  modport master (
    output run, ir_value, mem_ready, exec_done,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
    input  exec_start, opcode, instr_count, halted, mem_fault, state
  );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-bus fetch/decode sequencer with memory timeout
// Strobes and exec_start are decoded combinationally from the registered state.
module fetch_controller #(
  parameter int          OPCODE_HI    = 31,
  parameter int          OPCODE_LO    = 27,
  parameter logic [4:0]  HALT_OPCODE  = 5'b11011,
  parameter int          MEM_WAIT_MAX = 8,
  parameter int          COUNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  fetch_controller_if.slave bus
);
  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam int OP_W   = OPCODE_HI - OPCODE_LO + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T0      = 3'd1,
    S_T1      = 3'd2,
    S_MEMWAIT = 3'd3,
    S_T3      = 3'd4,
    S_DECODE  = 3'd5,
    S_EXEC    = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  logic [OP_W-1:0] op_field;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, rd, mdr_in, mdr_out, ir_in;
  logic exec_start;

  assign op_field = bus.ir_value[OPCODE_HI:OPCODE_LO];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      opcode_q   <= opcode_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    opcode_d   = opcode_q;
    count_d    = count_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    pc_out     = 1'b0;
    mar_in     = 1'b0;
    inc_pc     = 1'b0;
    z_in       = 1'b0;
    zlow_out   = 1'b0;
    pc_in      = 1'b0;
    rd         = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    ir_in      = 1'b0;
    exec_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_T0;
      end
      S_T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        zlow_out   = 1'b1;
        pc_in      = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        rd     = 1'b1;
        mdr_in = 1'b1;
        // Data arriving on the last allowed cycle still counts as a hit.
        if (bus.mem_ready) begin
          state_d = S_T3;
        end else if (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
          state_d  = S_HALT;
          fault_d  = 1'b1;
          halted_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_T3: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        opcode_d = op_field;
        if (op_field == HALT_OPCODE) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          exec_start = 1'b1;
          count_d    = count_q + 1'b1;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.exec_done) state_d = bus.run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.PCout       = pc_out;
  assign bus.MARin       = mar_in;
  assign bus.IncPC       = inc_pc;
  assign bus.Zin         = z_in;
  assign bus.Zlowout     = zlow_out;
  assign bus.PCin        = pc_in;
  assign bus.Read        = rd;
  assign bus.MDRin       = mdr_in;
  assign bus.MDRout      = mdr_out;
  assign bus.IRin        = ir_in;
  assign bus.exec_start  = exec_start;
  assign bus.opcode      = opcode_q;
  assign bus.instr_count = count_q;
  assign bus.halted      = halted_q;
  assign bus.mem_fault   = fault_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed bench for fetch_controller
// Runs with COUNT_W=4 so the counter wrap is reachable in a short run.
module tb_fetch_controller;
  localparam int CW = 4;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  fetch_controller_if #(.COUNT_W(CW)) bus ();

  fetch_controller #(
    .OPCODE_HI   (31),
    .OPCODE_LO   (27),
    .HALT_OPCODE (5'b11011),
    .MEM_WAIT_MAX(8),
    .COUNT_W     (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] strobes();
    return {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout,
            bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.ir_value  = 32'h0;
    bus.mem_ready = 1'b0;
    bus.exec_done = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_flags", {bus.exec_start, bus.halted, bus.mem_fault}, 3'b000);
    chk("rst_count", 32'(bus.instr_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_hold", 32'(bus.state), 32'd0);

    // 1: basic fetch, data on second MEMWAIT cycle
    bus.run = 1'b1;
    bus.ir_value = 32'h1800_0000;
    tick();
    chk("t1_T0", 32'(bus.state), 32'd1);
    chk("t1_T0_strb", 32'(strobes()), 32'b1111000000);
    tick();
    chk("t1_T1", 32'(bus.state), 32'd2);
    chk("t1_T1_strb", 32'(strobes()), 32'b0000110000);
    tick();
    chk("t1_MW1", 32'(bus.state), 32'd3);
    chk("t1_MW_strb", 32'(strobes()), 32'b0000001100);
    tick();
    chk("t1_MW2", 32'(bus.state), 32'd3);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("t1_T3", 32'(bus.state), 32'd4);
    chk("t1_T3_strb", 32'(strobes()), 32'b0000000011);
    tick();
    chk("t1_DEC", 32'(bus.state), 32'd5);
    chk("t1_start", 32'(bus.exec_start), 32'd1);
    chk("t1_DEC_strb", 32'(strobes()), 32'd0);
    bus.exec_done = 1'b1;  // must be ignored during DECODE
    tick();
    bus.exec_done = 1'b0;
    chk("t1_EXEC", 32'(bus.state), 32'd6);
    chk("t1_start_off", 32'(bus.exec_start), 32'd0);
    chk("t1_opcode", 32'(bus.opcode), 32'h03);
    chk("t1_count", 32'(bus.instr_count), 32'd1);
    tick();
    chk("t1_exec_wait", 32'(bus.state), 32'd6);

    // 4: exec_done with run=0 then run=1
    bus.run = 1'b0;
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    chk("t4_idle", 32'(bus.state), 32'd0);
    chk("t4_idle_strb", 32'(strobes()), 32'd0);
    tick();
    chk("t4_idle_hold", 32'(bus.state), 32'd0);
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.ir_value = 32'h0800_0000;
    tick();
    chk("t4_T0", 32'(bus.state), 32'd1);
    tick();
    tick();
    chk("t4_MW", 32'(bus.state), 32'd3);
    tick();
    chk("t4_T3", 32'(bus.state), 32'd4);
    tick();
    chk("t4_DEC", 32'(bus.state), 32'd5);
    tick();
    chk("t4_EXEC", 32'(bus.state), 32'd6);
    chk("t4_count", 32'(bus.instr_count), 32'd2);
    chk("t4_opcode", 32'(bus.opcode), 32'h01);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    chk("t4_back_T0", 32'(bus.state), 32'd1);

    // 6: counter wrap with COUNT_W=4 (instructions 3..16)
    for (int k = 3; k <= 16; k++) begin
      tick();
      tick();
      tick();
      tick();
      chk("t6_dec", 32'(bus.exec_start), 32'd1);
      tick();
      chk("t6_exec", 32'(bus.state), 32'd6);
      chk("t6_count", 32'(bus.instr_count), 32'(k % 16));
      chk("t6_halted", 32'(bus.halted), 32'd0);
      bus.exec_done = 1'b1;
      tick();
      bus.exec_done = 1'b0;
      chk("t6_T0", 32'(bus.state), 32'd1);
    end

    // 3: HALT opcode
    bus.ir_value = 32'hD800_0000;
    tick();
    tick();
    tick();
    tick();
    chk("t3_DEC", 32'(bus.state), 32'd5);
    chk("t3_no_start", 32'(bus.exec_start), 32'd0);
    tick();
    chk("t3_HALT", 32'(bus.state), 32'd7);
    chk("t3_halted", 32'(bus.halted), 32'd1);
    chk("t3_count", 32'(bus.instr_count), 32'd0);
    chk("t3_opcode", 32'(bus.opcode), 32'h1B);
    chk("t3_fault", 32'(bus.mem_fault), 32'd0);
    bus.exec_done = 1'b1;
    tick();
    tick();
    bus.exec_done = 1'b0;
    chk("t3_stuck", 32'(bus.state), 32'd7);
    chk("t3_strb", 32'(strobes()), 32'd0);

    // 5: async reset mid-MEMWAIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir_value = 32'h1800_0000;
    tick();
    tick();
    tick();
    chk("t5_MW", 32'(bus.state), 32'd3);
    chk("t5_read", 32'(bus.Read), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_state", 32'(bus.state), 32'd0);
    chk("t5_async_strb", 32'(strobes()), 32'd0);
    chk("t5_async_flags", {bus.halted, bus.mem_fault, bus.exec_start}, 3'b000);
    bus.run = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t5_post_state", 32'(bus.state), 32'd0);
    chk("t5_post_fault", 32'(bus.mem_fault), 32'd0);

    // 2: memory timeout after exactly 8 MEMWAIT cycles
    bus.run = 1'b1;
    tick();
    chk("t2_T0", 32'(bus.state), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_MW", 32'(bus.state), 32'd3);
      chk("t2_no_irin", 32'(bus.IRin), 32'd0);
    end
    tick();
    chk("t2_HALT", 32'(bus.state), 32'd7);
    chk("t2_fault", 32'(bus.mem_fault), 32'd1);
    chk("t2_halted", 32'(bus.halted), 32'd1);
    chk("t2_strb", 32'(strobes()), 32'd0);
    bus.mem_ready = 1'b1;
    tick();
    chk("t2_stuck", 32'(bus.state), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
